button_event_decoder: RTL and testbench

Consumes the clean, synchronous level produced by the team's debouncer and turns it into discrete one-clock user-interface events: press, short click, long press, auto-repeat and release. It sits between the per-button debouncer and the menu/control logic, one instance per button. Input is already synchronised to clk, so no CDC is done here.

---
 rtl/button_event_decoder_pkg.sv | 17 +
 rtl/button_event_decoder_ms_tick_gen.sv | 28 ++
 rtl/button_event_decoder.sv | 133 +++++++++++++
 tb/tb_button_event_decoder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/button_event_decoder_pkg.sv
// Shared types and helpers for the button event decoder and its ms timebase.
package button_event_pkg;

  typedef enum logic [1:0] {
    LOCKOUT = 2'd0,
    IDLE    = 2'd1,
    PRESSED = 2'd2,
    HOLD    = 2'd3
  } state_e;

  localparam int MS_CNT_W = 16;

  function automatic int ms_div(input int clk_hz);
    return clk_hz / 1000;
  endfunction

endpackage

// File: rtl/button_event_decoder_ms_tick_gen.sv
// Free-running prescaler: 1-cycle tick at terminal count DIV-1, sync clear.
module ms_tick_gen #(
  parameter int DIV = 27000
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] TC = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clr || cnt == TC) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == TC);

endmodule

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into press/click/long/repeat/release strobes.
module button_event_decoder
  import button_event_pkg::*;
#(
  parameter int   CLK_HZ        = 27000000,
  parameter logic IDLE_STATE    = 1'b1,
  parameter int   LONG_PRESS_MS = 800,
  parameter int   REPEAT_MS     = 200
) (
  input  logic   clk,
  input  logic   rstn,
  input  logic   btn_in,
  output logic   pressed,
  output logic   press_pulse,
  output logic   click_pulse,
  output logic   long_pulse,
  output logic   repeat_pulse,
  output logic   release_pulse,
  output state_e dbg_state
);

  localparam int DIV = ms_div(CLK_HZ);
  localparam logic [MS_CNT_W-1:0] LONG_M1 = MS_CNT_W'(LONG_PRESS_MS - 1);
  localparam logic [MS_CNT_W-1:0] RPT_M1  = MS_CNT_W'((REPEAT_MS == 0) ? 0 : REPEAT_MS - 1);
  localparam bit RPT_EN = (REPEAT_MS != 0);

  state_e state_q, state_d;
  logic btn_1, act, act_1, rise, fall;
  logic tick, pre_clr, ms_clr, long_hit, rpt_hit;
  logic [MS_CNT_W-1:0] ms_cnt;
  logic pressed_d, press_d, click_d, long_d, repeat_d, release_d;

  assign act   = (btn_in != IDLE_STATE);
  assign act_1 = (btn_1 != IDLE_STATE);
  assign rise  = act & ~act_1;
  assign fall  = ~act & act_1;

  // Expiry is detected on the tick that would take ms_cnt to the target, so
  // the strobe lands exactly N*DIV cycles after the event that cleared timing.
  assign long_hit = tick && (ms_cnt == LONG_M1);
  assign rpt_hit  = RPT_EN && tick && (ms_cnt == RPT_M1);

  ms_tick_gen #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rstn (rstn),
    .clr  (pre_clr),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= LOCKOUT;
      btn_1   <= IDLE_STATE;
    end else begin
      state_q <= state_d;
      btn_1   <= btn_in;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOCKOUT: if (!act) state_d = IDLE;
      IDLE:    if (rise) state_d = PRESSED;
      PRESSED: begin
        if (fall)          state_d = IDLE;
        else if (long_hit) state_d = HOLD;
      end
      HOLD:    if (fall) state_d = IDLE;
      default: state_d = LOCKOUT;
    endcase
  end

  // Release has priority over a same-cycle long/repeat expiry.
  always_comb begin
    press_d   = 1'b0;
    click_d   = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    release_d = 1'b0;
    case (state_q)
      IDLE:    press_d = rise;
      PRESSED: begin
        if (fall) begin
          click_d   = 1'b1;
          release_d = 1'b1;
        end else begin
          long_d = long_hit;
        end
      end
      HOLD: begin
        if (fall) release_d = 1'b1;
        else      repeat_d  = rpt_hit;
      end
      default: ;
    endcase
    pressed_d = (state_d == PRESSED) || (state_d == HOLD);
  end

  assign pre_clr = rise | long_d;
  assign ms_clr  = press_d | long_d | repeat_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ms_cnt <= '0;
    end else if (ms_clr) begin
      ms_cnt <= '0;
    end else if (tick && ms_cnt != '1) begin
      ms_cnt <= ms_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pressed       <= 1'b0;
      press_pulse   <= 1'b0;
      click_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      pressed       <= pressed_d;
      press_pulse   <= press_d;
      click_pulse   <= click_d;
      long_pulse    <= long_d;
      repeat_pulse  <= repeat_d;
      release_pulse <= release_d;
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder at 10 cycles/ms, long=5 ms, repeat=2 ms.
module tb_button_event_decoder;
  import button_event_pkg::*;

  localparam int CLK_HZ  = 10000;
  localparam int LONG_MS = 5;
  localparam int RPT_MS  = 2;

  // Output vector layout: {pressed, press, click, long, repeat, release}
  localparam logic [5:0] Z  = 6'b000000;
  localparam logic [5:0] P  = 6'b100000;
  localparam logic [5:0] PR = 6'b010000;
  localparam logic [5:0] CL = 6'b001000;
  localparam logic [5:0] LG = 6'b000100;
  localparam logic [5:0] RP = 6'b000010;
  localparam logic [5:0] RL = 6'b000001;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic btn_in = 1'b1;

  logic pressed, press_pulse, click_pulse, long_pulse, repeat_pulse, release_pulse;
  logic pressed_n, press_n, click_n, long_n, repeat_n, release_n;
  state_e dbg_state, dbg_state_n;
  logic [5:0] obs, obs_n;

  typedef struct {
    logic       btn;
    logic [5:0] exp;
  } vec_t;

  vec_t       vec_q[$];
  logic [5:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  // ---------------- clock / DUTs ----------------
  always #5 clk = ~clk;

  button_event_decoder #(
    .CLK_HZ(CLK_HZ), .IDLE_STATE(1'b1), .LONG_PRESS_MS(LONG_MS), .REPEAT_MS(RPT_MS)
  ) dut (
    .clk(clk), .rstn(rstn), .btn_in(btn_in),
    .pressed(pressed), .press_pulse(press_pulse), .click_pulse(click_pulse),
    .long_pulse(long_pulse), .repeat_pulse(repeat_pulse), .release_pulse(release_pulse),
    .dbg_state(dbg_state)
  );

  button_event_decoder #(
    .CLK_HZ(CLK_HZ), .IDLE_STATE(1'b1), .LONG_PRESS_MS(LONG_MS), .REPEAT_MS(0)
  ) dut_norpt (
    .clk(clk), .rstn(rstn), .btn_in(btn_in),
    .pressed(pressed_n), .press_pulse(press_n), .click_pulse(click_n),
    .long_pulse(long_n), .repeat_pulse(repeat_n), .release_pulse(release_n),
    .dbg_state(dbg_state_n)
  );

  assign obs   = {pressed, press_pulse, click_pulse, long_pulse, repeat_pulse, release_pulse};
  assign obs_n = {pressed_n, press_n, click_n, long_n, repeat_n, release_n};

  // ---------------- driver tasks ----------------
  task automatic step(input logic b);
    @(negedge clk);
    btn_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic void add(input logic b, input logic [5:0] e);
    vec_t v;
    v.btn = b;
    v.exp = e;
    vec_q.push_back(v);
  endfunction

  // ---------------- stimulus / scoreboard ----------------
  initial begin
    logic [5:0] acc;
    logic [5:0] e;
    int long_cnt, long_pos, rpt_cnt;

    // short click
    add(1'b1, Z);
    add(1'b0, P | PR);
    for (int k = 1; k < 20; k++) add(1'b0, P);
    add(1'b1, CL | RL);
    add(1'b1, Z);
    // long hold with repeats, release without click
    add(1'b0, P | PR);
    for (int k = 1; k < 120; k++) begin
      e = P;
      if (k == 50) e = e | LG;
      if (k >= 70 && (k - 70) % 20 == 0) e = e | RP;
      add(1'b0, e);
    end
    add(1'b1, RL);
    add(1'b1, Z);
    // release sampled on the long-expiry edge: click wins, no long
    add(1'b0, P | PR);
    for (int k = 1; k < 50; k++) add(1'b0, P);
    add(1'b1, CL | RL);
    for (int k = 0; k < 5; k++) add(1'b1, Z);
    // release sampled on the first repeat-expiry edge: release only
    add(1'b0, P | PR);
    for (int k = 1; k < 70; k++) add(1'b0, (k == 50) ? (P | LG) : P);
    add(1'b1, RL);
    for (int k = 0; k < 5; k++) add(1'b1, Z);

    // reset state
    rstn = 1'b0;
    btn_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", obs, Z);
    check("reset_state", {4'b0, dbg_state}, {4'b0, LOCKOUT});
    @(negedge clk);
    rstn = 1'b1;

    foreach (vec_q[i]) begin
      exp_q.push_back(vec_q[i].exp);
      step(vec_q[i].btn);
      check($sformatf("vec%0d", i), obs, exp_q.pop_front());
    end

    // REPEAT_MS=0: single long pulse, never a repeat
    long_cnt = 0;
    long_pos = -1;
    rpt_cnt  = 0;
    for (int k = 0; k < 200; k++) begin
      step(1'b0);
      if (k == 0) check("norpt_press", obs_n, P | PR);
      if (long_n) begin
        long_cnt++;
        long_pos = k;
      end
      if (repeat_n) rpt_cnt++;
    end
    check("norpt_long_count", 6'(long_cnt), 6'd1);
    check("norpt_long_pos", 6'(long_pos), 6'd50);
    check("norpt_repeat_count", 6'(rpt_cnt), 6'd0);
    step(1'b1);
    check("norpt_release", obs_n, RL);
    step(1'b1);

    // button held through reset: lockout until released
    @(negedge clk);
    rstn = 1'b0;
    btn_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    acc = Z;
    for (int k = 0; k < 30; k++) begin
      step(1'b0);
      acc = acc | obs;
    end
    check("lockout_silent", acc, Z);
    check("lockout_state", {4'b0, dbg_state}, {4'b0, LOCKOUT});
    step(1'b1);
    check("lockout_release_silent", obs, Z);
    step(1'b1);
    step(1'b0);
    check("post_lockout_press", obs, P | PR);
    for (int k = 1; k < 56; k++) step(1'b0);
    check("in_hold_state", {4'b0, dbg_state}, {4'b0, HOLD});
    check("in_hold_outputs", obs, P);

    // async reset mid-hold: outputs drop at once, no release strobe
    @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check("async_reset_outputs", obs, Z);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    acc = Z;
    for (int k = 0; k < 20; k++) begin
      step(1'b0);
      acc = acc | obs;
    end
    check("post_reset_lockout", acc, Z);
    step(1'b1);
    check("post_reset_release_silent", obs, Z);
    step(1'b0);
    check("post_reset_press", obs, P | PR);
    step(1'b1);
    check("post_reset_click", obs, CL | RL);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
